writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/wb_pkg.sv | 32 +++
 rtl/load_align.sv | 25 ++
 rtl/writeback_stage.sv | 178 +++++++++++++++++
 tb/tb_writeback_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: FSM encoding, load timeout,
// link offset and byte-lane numbering for big-endian load alignment.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2
    } wb_state_e;

    localparam logic [7:0]  WB_MEM_TIMEOUT = 8'd255;
    localparam logic [31:0] LINK_OFFSET    = 32'd8;
    localparam logic [4:0]  LINK_REG       = 5'd31;

    // Lane number is the low address bits; lane 0 is the most significant byte.
    localparam logic [1:0] LANE_0 = 2'd0;
    localparam logic [1:0] LANE_1 = 2'd1;
    localparam logic [1:0] LANE_2 = 2'd2;
    localparam logic [1:0] LANE_3 = 2'd3;

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            LANE_0:  b = word[31:24];
            LANE_1:  b = word[23:16];
            LANE_2:  b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: passes whole words through, or selects one
// big-endian byte lane and zero/sign-extends it.
import wb_pkg::*;

module load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic        access_size,
    input  logic        sign_x,
    output logic [31:0] data
);

    logic [7:0] byte_sel;

    // Lane select and extension
    always_comb begin
        byte_sel = lane_byte(rdata, lane);
        if (access_size) begin
            data = rdata;
        end else begin
            data = {{24{sign_x & byte_sel[7]}}, byte_sel};
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: retires one instruction at a time into the register file,
// waiting on memory for loads. Optional macro WB_BYPASS_EN exposes the
// register-file write port combinationally for decode-stage forwarding.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | ready for a new instruction (in_ready=1)
// ST_WAIT_MEM | load issued, waiting for mem_rvalid or timeout
// ST_WRITE    | one cycle in which the registered rf_we is presented
import wb_pkg::*;

module writeback_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] pc,
    input  logic [31:0] alu_result,
    input  logic        rwd,
    input  logic        link,
    input  logic        rwe,
    input  logic [4:0]  dest_addr,
    input  logic        access_size,
    input  logic        sign_x,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data,
    output logic        err_align,
    output logic        err_timeout,
    output logic        busy,
    output logic        byp_valid,
    output logic [4:0]  byp_addr,
    output logic [31:0] byp_data
);

    wb_state_e   state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        capture;
    logic        we_nxt, align_nxt, timeout_nxt;
    logic [4:0]  addr_nxt;
    logic [31:0] data_nxt;

    logic [4:0]  cap_addr;
    logic [31:0] cap_link_data;
    logic [1:0]  cap_lane;
    logic        cap_link, cap_rwe, cap_size, cap_sx;

    logic [4:0]  in_wr_addr;
    logic [31:0] in_link_data;
    logic [31:0] load_data;

    assign in_wr_addr   = link ? LINK_REG : dest_addr;
    assign in_link_data = pc + LINK_OFFSET;
    assign in_ready     = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);

    load_align u_load_align (
        .rdata       (mem_rdata),
        .lane        (cap_lane),
        .access_size (cap_size),
        .sign_x      (cap_sx),
        .data        (load_data)
    );

    // State and wait counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state and next register-file/error outputs; rf_we is set on the
    // edge entering ST_WRITE so it is high for exactly that cycle
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        capture     = 1'b0;
        we_nxt      = 1'b0;
        addr_nxt    = rf_addr;
        data_nxt    = rf_data;
        align_nxt   = 1'b0;
        timeout_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    capture = 1'b1;
                    cnt_nxt = 8'd0;
                    if (rwd) begin
                        state_nxt = ST_WAIT_MEM;
                    end else begin
                        state_nxt = ST_WRITE;
                        we_nxt    = rwe && (in_wr_addr != 5'd0);
                        if (we_nxt) begin
                            addr_nxt = in_wr_addr;
                            data_nxt = link ? in_link_data : alu_result;
                        end
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (mem_rvalid) begin
                    if (cap_size && (cap_lane != 2'd0)) begin
                        state_nxt = ST_IDLE;
                        align_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_WRITE;
                        we_nxt    = cap_rwe && (cap_addr != 5'd0);
                        if (we_nxt) begin
                            addr_nxt = cap_addr;
                            data_nxt = cap_link ? cap_link_data : load_data;
                        end
                    end
                end else if (cnt == WB_MEM_TIMEOUT) begin
                    state_nxt   = ST_IDLE;
                    timeout_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            ST_WRITE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output registers and captured instruction fields
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we         <= 1'b0;
            rf_addr       <= 5'd0;
            rf_data       <= 32'd0;
            err_align     <= 1'b0;
            err_timeout   <= 1'b0;
            cap_addr      <= 5'd0;
            cap_link_data <= 32'd0;
            cap_lane      <= 2'd0;
            cap_link      <= 1'b0;
            cap_rwe       <= 1'b0;
            cap_size      <= 1'b0;
            cap_sx        <= 1'b0;
        end else begin
            rf_we       <= we_nxt;
            rf_addr     <= addr_nxt;
            rf_data     <= data_nxt;
            err_align   <= align_nxt;
            err_timeout <= timeout_nxt;
            if (capture) begin
                cap_addr      <= in_wr_addr;
                cap_link_data <= in_link_data;
                cap_lane      <= alu_result[1:0];
                cap_link      <= link;
                cap_rwe       <= rwe;
                cap_size      <= access_size;
                cap_sx        <= sign_x;
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign byp_valid = rf_we;
    assign byp_addr  = rf_addr;
    assign byp_data  = rf_data;
`else
    assign byp_valid = 1'b0;
    assign byp_addr  = 5'd0;
    assign byp_data  = 32'd0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: stimulus tasks push expected
// register writes / error pulses (with the cycle they must appear in) and a
// negedge monitor pops and compares whenever the DUT raises rf_we or an error.
module tb_writeback_stage;

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [31:0] pc, alu_result;
    logic        rwd, link, rwe;
    logic [4:0]  dest_addr;
    logic        access_size, sign_x;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        err_align, err_timeout, busy;
    logic        byp_valid;
    logic [4:0]  byp_addr;
    logic [31:0] byp_data;

    localparam int K_WRITE = 0;
    localparam int K_ALIGN = 1;
    localparam int K_TOUT  = 2;
    localparam int K_NONE  = -1;

    typedef struct {
        int          kind;
        logic [4:0]  addr;
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t        sb[$];
    exp_t        me;
    int          mk;
    int          cyc;
    int          n_checks, n_pass;
    logic [4:0]  last_addr;
    logic [31:0] last_data;

    writeback_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .pc          (pc),
        .alu_result  (alu_result),
        .rwd         (rwd),
        .link        (link),
        .rwe         (rwe),
        .dest_addr   (dest_addr),
        .access_size (access_size),
        .sign_x      (sign_x),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .rf_we       (rf_we),
        .rf_addr     (rf_addr),
        .rf_data     (rf_data),
        .err_align   (err_align),
        .err_timeout (err_timeout),
        .busy        (busy),
        .byp_valid   (byp_valid),
        .byp_addr    (byp_addr),
        .byp_data    (byp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic void push(input int kind, input logic [4:0] a, input logic [31:0] d, input int at);
        exp_t e;
        e.kind = kind; e.addr = a; e.data = d; e.at = at;
        sb.push_back(e);
    endfunction

    // Monitor: every write or error pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && (rf_we || err_align || err_timeout)) begin
            mk = rf_we ? K_WRITE : (err_align ? K_ALIGN : K_TOUT);
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", mk, cyc);
            end else begin
                me = sb.pop_front();
                check("event_kind", mk, me.kind);
                check("event_cycle", cyc, me.at);
                if (me.kind == K_WRITE) begin
                    check("rf_addr", {27'd0, rf_addr}, {27'd0, me.addr});
                    check("rf_data", rf_data, me.data);
`ifdef WB_BYPASS_EN
                    check("byp_valid", {31'd0, byp_valid}, 32'd1);
                    check("byp_addr", {27'd0, byp_addr}, {27'd0, me.addr});
                    check("byp_data", byp_data, me.data);
`else
                    check("byp_valid", {31'd0, byp_valid}, 32'd0);
                    check("byp_addr", {27'd0, byp_addr}, 32'd0);
                    check("byp_data", byp_data, 32'd0);
`endif
                    last_addr = me.addr;
                    last_data = me.data;
                end
            end
        end
    end

    // Present one instruction for one cycle; optionally expect a write next cycle
    task automatic issue(input logic [31:0] p, input logic [31:0] a, input logic rd,
                         input logic lk, input logic we, input logic [4:0] d,
                         input logic sz, input logic sx,
                         input int ek, input logic [4:0] ea, input logic [31:0] ed);
        @(negedge clk);
        check("in_ready", {31'd0, in_ready}, 32'd1);
        if (ek != K_NONE) push(ek, ea, ed, cyc + 1);
        pc = p; alu_result = a; rwd = rd; link = lk; rwe = we;
        dest_addr = d; access_size = sz; sign_x = sx;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Return load data after n_wait further cycles
    task automatic mem_rsp(input int n_wait, input logic [31:0] d,
                           input int ek, input logic [4:0] ea, input logic [31:0] ed);
        repeat (n_wait) @(negedge clk);
        if (ek != K_NONE) push(ek, ea, ed, cyc + 1);
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
    endtask

    task automatic check_idle_hold(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_rf_addr_hold"}, {27'd0, rf_addr}, {27'd0, last_addr});
        check({tag, "_rf_data_hold"}, rf_data, last_data);
`ifdef WB_BYPASS_EN
        check({tag, "_byp_addr"}, {27'd0, byp_addr}, {27'd0, last_addr});
`else
        check({tag, "_byp_addr"}, {27'd0, byp_addr}, 32'd0);
`endif
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        last_addr = 5'd0; last_data = 32'd0;
        rst = 1'b1; in_valid = 1'b0; pc = 32'd0; alu_result = 32'd0;
        rwd = 1'b0; link = 1'b0; rwe = 1'b0; dest_addr = 5'd0;
        access_size = 1'b0; sign_x = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_rf_we", {31'd0, rf_we}, 32'd0);
        check("rst_rf_addr", {27'd0, rf_addr}, 32'd0);
        check("rst_rf_data", rf_data, 32'd0);
        check("rst_err_align", {31'd0, err_align}, 32'd0);
        check("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_byp", {26'd0, byp_valid, byp_addr} | byp_data, 32'd0);
        rst = 1'b0;

        // ALU result
        issue(32'h0000_0100, 32'h0000_1234, 0, 0, 1, 5'd5, 1, 0, K_WRITE, 5'd5, 32'h0000_1234);
        // Link writes pc+8 to r31
        issue(32'h0040_0010, 32'h0, 0, 1, 1, 5'd7, 1, 0, K_WRITE, 5'd31, 32'h0040_0018);
        // Link PC wraps modulo 2^32
        issue(32'hFFFF_FFFC, 32'h0, 0, 1, 1, 5'd2, 1, 0, K_WRITE, 5'd31, 32'h0000_0004);

        // Byte loads, lane 1, sign and zero extension
        issue(32'h0, 32'h0000_1001, 1, 0, 1, 5'd9, 0, 1, K_NONE, 5'd0, 32'd0);
        mem_rsp(3, 32'h12F0_5678, K_WRITE, 5'd9, 32'hFFFF_FFF0);
        issue(32'h0, 32'h0000_1001, 1, 0, 1, 5'd10, 0, 0, K_NONE, 5'd0, 32'd0);
        mem_rsp(3, 32'h12F0_5678, K_WRITE, 5'd10, 32'h0000_00F0);
        // Lanes 0, 2, 3
        issue(32'h0, 32'h0000_1000, 1, 0, 1, 5'd11, 0, 1, K_NONE, 5'd0, 32'd0);
        mem_rsp(0, 32'h12F0_5678, K_WRITE, 5'd11, 32'h0000_0012);
        issue(32'h0, 32'h0000_1002, 1, 0, 1, 5'd12, 0, 1, K_NONE, 5'd0, 32'd0);
        mem_rsp(1, 32'h0000_8000, K_WRITE, 5'd12, 32'hFFFF_FF80);
        issue(32'h0, 32'h0000_1003, 1, 0, 1, 5'd13, 0, 0, K_NONE, 5'd0, 32'd0);
        mem_rsp(2, 32'hAABB_CCDD, K_WRITE, 5'd13, 32'h0000_00DD);
        // Aligned word load
        issue(32'h0, 32'h0000_2000, 1, 0, 1, 5'd14, 1, 0, K_NONE, 5'd0, 32'd0);
        mem_rsp(4, 32'hDEAD_BEEF, K_WRITE, 5'd14, 32'hDEAD_BEEF);
        // Misaligned word load: error pulse, no write
        issue(32'h0, 32'h0000_2002, 1, 0, 1, 5'd15, 1, 0, K_NONE, 5'd0, 32'd0);
        mem_rsp(2, 32'h1111_2222, K_ALIGN, 5'd0, 32'd0);

        // r0 and rwe=0 never write; outputs hold last write
        issue(32'h0, 32'h0000_5555, 0, 0, 1, 5'd0, 1, 0, K_NONE, 5'd0, 32'd0);
        issue(32'h0, 32'h0000_6666, 0, 0, 0, 5'd3, 1, 0, K_NONE, 5'd0, 32'd0);
        @(negedge clk);
        check_idle_hold("nowrite");

        // mem_rvalid while idle is ignored
        mem_rsp(0, 32'hCAFE_F00D, K_NONE, 5'd0, 32'd0);
        repeat (2) @(negedge clk);
        check_idle_hold("stray_rvalid");

        // in_valid during WAIT_MEM is ignored
        issue(32'h0, 32'h0000_3000, 1, 0, 1, 5'd20, 1, 0, K_NONE, 5'd0, 32'd0);
        check("waitmem_in_ready", {31'd0, in_ready}, 32'd0);
        check("waitmem_busy", {31'd0, busy}, 32'd1);
        alu_result = 32'h0000_7777; rwd = 1'b0; dest_addr = 5'd21; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        mem_rsp(1, 32'h0BAD_F00D, K_WRITE, 5'd20, 32'h0BAD_F00D);

        // Timeout: no rvalid, error pulse after the counter reaches 255
        issue(32'h0, 32'h0000_4000, 1, 0, 1, 5'd22, 1, 0, K_NONE, 5'd0, 32'd0);
        push(K_TOUT, 5'd0, 32'd0, cyc + 256);
        repeat (260) @(negedge clk);
        check_idle_hold("after_timeout");

        // rvalid on the timeout cycle still wins
        issue(32'h0, 32'h0000_4004, 1, 0, 1, 5'd23, 1, 0, K_NONE, 5'd0, 32'd0);
        mem_rsp(255, 32'h5A5A_A5A5, K_WRITE, 5'd23, 32'h5A5A_A5A5);
        repeat (2) @(negedge clk);

        // Reset mid-load abandons it; later rvalid ignored
        issue(32'h0, 32'h0000_4008, 1, 0, 1, 5'd24, 1, 0, K_NONE, 5'd0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_addr = 5'd0; last_data = 32'd0;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_rf_data", rf_data, 32'd0);
        mem_rsp(0, 32'h7777_8888, K_NONE, 5'd0, 32'd0);
        repeat (2) @(negedge clk);
        check_idle_hold("rst_mid_after_rvalid");

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
